// File: rtl/halflife_pkg.sv
// Shared types, default widths and the per-half-life quota helper for the
// half-life sequencer.
package halflife_pkg;

    localparam int N_DEF    = 4;
    localparam int HL_W_DEF = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        DECAY,
        DONE
    } state_e;

    // ceil(x/2): the number of units removed in one half-life step
    function automatic logic [15:0] ceil_half(input logic [15:0] x);
        return x - (x >> 1);
    endfunction

endpackage

// File: rtl/halflife_if.sv
// Command/status bundle between control logic and the half-life sequencer.
// The abort input exists only when HALFLIFE_ABORT_EN is defined.
interface halflife_if
    import halflife_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int HL_W = HL_W_DEF
);
    logic            start;
    logic [N-1:0]    init_count;
    logic [HL_W-1:0] half_life;
`ifdef HALFLIFE_ABORT_EN
    logic            abort;
`endif
    logic            cmd_load;
    logic [N-1:0]    load_val;
    logic            cmd_down;
    logic [N-1:0]    shadow_count;
    logic [N-1:0]    halvings;
    logic            busy;
    logic            done;

    modport master (
        output start, init_count, half_life,
`ifdef HALFLIFE_ABORT_EN
        output abort,
`endif
        input  cmd_load, load_val, cmd_down, shadow_count, halvings, busy, done
    );

    modport slave (
        input  start, init_count, half_life,
`ifdef HALFLIFE_ABORT_EN
        input  abort,
`endif
        output cmd_load, load_val, cmd_down, shadow_count, halvings, busy, done
    );

endinterface

// File: rtl/halflife_period_timer.sv
// Loadable down-counter timing one half-life. expire_o fires on the last
// ticked cycle of the loaded period.
module halflife_period_timer #(
    parameter int HL_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_i,
    input  logic [HL_W-1:0] value_i,
    input  logic            tick_i,
    output logic            expire_o
);
    logic [HL_W-1:0] cnt_q;
    logic [HL_W-1:0] cnt_d;

    // next count: reload, or step down while ticking
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (tick_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = tick_i && (cnt_q <= HL_W'(1));

endmodule

// File: rtl/halflife_sequencer.sv
// Half-life sequencer: loads the counter, then issues ceil(count/2) down
// commands per half-life until the population is zero.
// Optional feature macro: HALFLIFE_ABORT_EN (adds an abort input).
module halflife_sequencer
    import halflife_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int HL_W = HL_W_DEF
) (
    input logic       clk,
    input logic       rst,
    halflife_if.slave bus
);
    state_e          state_q, state_d;
    logic [N-1:0]    init_q, init_d;
    logic [HL_W-1:0] hl_q, hl_d;
    logic [N-1:0]    shadow_q, shadow_d;
    logic [N-1:0]    halv_q, halv_d;
    logic [N-1:0]    quota_q, quota_d;
    logic            cmd_load_q, cmd_down_q, busy_q, done_q;
    logic [N-1:0]    load_val_q;
    logic            tmr_load, tmr_tick, tmr_expire;
    logic [HL_W-1:0] hl_eff;
    logic            abort_req;

`ifdef HALFLIFE_ABORT_EN
    assign abort_req = bus.abort;
`else
    assign abort_req = 1'b0;
`endif

    // a zero half-life is run as a one-cycle wait
    assign hl_eff = (hl_q == '0) ? HL_W'(1) : hl_q;

    halflife_period_timer #(.HL_W(HL_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (tmr_load),
        .value_i  (hl_eff),
        .tick_i   (tmr_tick),
        .expire_o (tmr_expire)
    );

    // next-state, captured run parameters and shadow bookkeeping
    always_comb begin
        state_d  = state_q;
        init_d   = init_q;
        hl_d     = hl_q;
        shadow_d = shadow_q;
        halv_d   = halv_q;
        quota_d  = quota_q;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    init_d  = bus.init_count;
                    hl_d    = bus.half_life;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                shadow_d = init_q;
                halv_d   = '0;
                tmr_load = 1'b1;
                state_d  = (init_q == '0) ? DONE : WAIT;
            end
            WAIT: begin
                tmr_tick = 1'b1;
                if (tmr_expire) begin
                    quota_d = N'(ceil_half(16'(shadow_q)));
                    state_d = DECAY;
                end
            end
            DECAY: begin
                if (shadow_q != '0) begin
                    shadow_d = shadow_q - 1'b1;
                end
                quota_d = quota_q - 1'b1;
                if (quota_q <= N'(1)) begin
                    halv_d = (&halv_q) ? halv_q : halv_q + 1'b1;
                    if (shadow_q <= N'(1)) begin
                        state_d = DONE;
                    end else begin
                        tmr_load = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // abort drops straight back to IDLE, leaving shadow/halvings as they were
        if (abort_req && (state_q != IDLE)) begin
            state_d  = IDLE;
            shadow_d = shadow_q;
            halv_d   = halv_q;
            tmr_load = 1'b0;
        end
    end

    // state, bookkeeping and registered command/status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            init_q     <= '0;
            hl_q       <= '0;
            shadow_q   <= '0;
            halv_q     <= '0;
            quota_q    <= '0;
            cmd_load_q <= 1'b0;
            load_val_q <= '0;
            cmd_down_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            hl_q       <= hl_d;
            shadow_q   <= shadow_d;
            halv_q     <= halv_d;
            quota_q    <= quota_d;
            cmd_load_q <= (state_d == LOAD);
            load_val_q <= (state_d == LOAD) ? init_d : '0;
            cmd_down_q <= (state_d == DECAY);
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign bus.cmd_load     = cmd_load_q;
    assign bus.load_val     = load_val_q;
    assign bus.cmd_down     = cmd_down_q;
    assign bus.shadow_count = shadow_q;
    assign bus.halvings     = halv_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;

endmodule

// File: tb/tb_halflife_sequencer.sv
// Directed bench for halflife_sequencer. Cycle 0 is the cycle in which start
// is sampled; outputs are recorded at the falling edge of each later cycle.
module tb_halflife_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passed = 0;

    logic [63:0] down_m, done_m, load_m, busy_m;
    logic [3:0]  sh_log [64];
    logic [3:0]  hv_log [64];
    logic [3:0]  lv_log [64];

    halflife_if #(.N(4), .HL_W(8)) bus ();

    halflife_sequencer #(.N(4), .HL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // ev_kind: 0 none, 1 stray start with new inputs, 2 reset, 3 abort
    task automatic run(input logic [3:0] init, input logic [7:0] hl, input int ncyc,
                       input int ev_c, input int ev_kind);
        down_m = '0; done_m = '0; load_m = '0; busy_m = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.init_count = init; bus.half_life = hl;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            rst = 1'b0;
`ifdef HALFLIFE_ABORT_EN
            bus.abort = 1'b0;
`endif
            down_m[c] = bus.cmd_down;
            done_m[c] = bus.done;
            load_m[c] = bus.cmd_load;
            busy_m[c] = bus.busy;
            sh_log[c] = bus.shadow_count;
            hv_log[c] = bus.halvings;
            lv_log[c] = bus.load_val;
            if (c == ev_c) begin
                if (ev_kind == 1) begin
                    bus.start = 1'b1; bus.init_count = 4'd2; bus.half_life = 8'd1;
                end else if (ev_kind == 2) begin
                    rst = 1'b1;
                end
`ifdef HALFLIFE_ABORT_EN
                else if (ev_kind == 3) begin
                    bus.abort = 1'b1;
                end
`endif
            end
        end
        bus.start = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.cmd_load, bus.load_val, bus.cmd_down, bus.shadow_count, bus.halvings,
             bus.busy, bus.done} !== 15'd0) $display("FAIL reset_outputs got=%h want=0",
            {bus.cmd_load, bus.load_val, bus.cmd_down, bus.shadow_count, bus.halvings,
             bus.busy, bus.done});
        else passed++;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle busy=%b want=0", bus.busy);
        else passed++;
    endtask

    task automatic test_basic();
        run(4'd8, 8'd3, 24, 0, 0);
        checks++; if (load_m !== 64'h2) $display("FAIL basic_load got=%h want=2", load_m); else passed++;
        checks++; if (lv_log[1] !== 4'd8) $display("FAIL basic_loadval got=%0d want=8", lv_log[1]); else passed++;
        checks++; if (lv_log[2] !== 4'd0) $display("FAIL basic_loadval_idle got=%0d want=0", lv_log[2]); else passed++;
        checks++; if (down_m !== 64'h2231E0) $display("FAIL basic_down got=%h want=2231e0", down_m); else passed++;
        checks++; if (done_m !== 64'h400000) $display("FAIL basic_done got=%h want=400000", done_m); else passed++;
        checks++; if (busy_m !== 64'h7FFFFE) $display("FAIL basic_busy got=%h want=7ffffe", busy_m); else passed++;
        checks++; if (sh_log[2] !== 4'd8) $display("FAIL basic_shadow_load got=%0d want=8", sh_log[2]); else passed++;
        checks++; if (sh_log[9] !== 4'd4) $display("FAIL basic_shadow_burst1 got=%0d want=4", sh_log[9]); else passed++;
        checks++; if (hv_log[22] !== 4'd4) $display("FAIL basic_halvings got=%0d want=4", hv_log[22]); else passed++;
        checks++; if (sh_log[22] !== 4'd0) $display("FAIL basic_shadow_end got=%0d want=0", sh_log[22]); else passed++;
    endtask

    task automatic test_zero_init();
        run(4'd0, 8'd5, 4, 0, 0);
        checks++; if (load_m !== 64'h2) $display("FAIL zero_load got=%h want=2", load_m); else passed++;
        checks++; if (done_m !== 64'h4) $display("FAIL zero_done got=%h want=4", done_m); else passed++;
        checks++; if (down_m !== 64'h0) $display("FAIL zero_down got=%h want=0", down_m); else passed++;
        checks++; if (busy_m !== 64'h6) $display("FAIL zero_busy got=%h want=6", busy_m); else passed++;
        checks++; if (hv_log[2] !== 4'd0) $display("FAIL zero_halvings got=%0d want=0", hv_log[2]); else passed++;
    endtask

    task automatic test_hl_zero();
        run(4'd15, 8'd0, 23, 0, 0);
        checks++; if (down_m !== 64'h16F7F8) $display("FAIL hl0_down got=%h want=16f7f8", down_m); else passed++;
        checks++; if ($countones(down_m) != 15) $display("FAIL hl0_pulses got=%0d want=15", $countones(down_m)); else passed++;
        checks++; if (done_m !== 64'h200000) $display("FAIL hl0_done got=%h want=200000", done_m); else passed++;
        checks++; if (busy_m !== 64'h3FFFFE) $display("FAIL hl0_busy got=%h want=3ffffe", busy_m); else passed++;
        checks++; if (hv_log[21] !== 4'd4) $display("FAIL hl0_halvings got=%0d want=4", hv_log[21]); else passed++;
        checks++; if (sh_log[21] !== 4'd0) $display("FAIL hl0_shadow got=%0d want=0", sh_log[21]); else passed++;
    endtask

    task automatic test_start_ignored();
        run(4'd8, 8'd3, 24, 6, 1);
        checks++; if (load_m !== 64'h2) $display("FAIL ign_load got=%h want=2", load_m); else passed++;
        checks++; if (down_m !== 64'h2231E0) $display("FAIL ign_down got=%h want=2231e0", down_m); else passed++;
        checks++; if (done_m !== 64'h400000) $display("FAIL ign_done got=%h want=400000", done_m); else passed++;
        checks++; if (hv_log[22] !== 4'd4) $display("FAIL ign_halvings got=%0d want=4", hv_log[22]); else passed++;
    endtask

    task automatic test_reset_mid_run();
        run(4'd8, 8'd3, 7, 6, 2);
        checks++; if (down_m !== 64'h60) $display("FAIL rstmid_down got=%h want=60", down_m); else passed++;
        checks++; if (sh_log[6] !== 4'd7) $display("FAIL rstmid_shadow_before got=%0d want=7", sh_log[6]); else passed++;
        checks++; if (busy_m[7] !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", busy_m[7]); else passed++;
        checks++; if (sh_log[7] !== 4'd0) $display("FAIL rstmid_shadow got=%0d want=0", sh_log[7]); else passed++;
        checks++; if (hv_log[7] !== 4'd0) $display("FAIL rstmid_halvings got=%0d want=0", hv_log[7]); else passed++;
        checks++; if (done_m !== 64'h0) $display("FAIL rstmid_done got=%h want=0", done_m); else passed++;
        run(4'd3, 8'd2, 11, 0, 0);
        checks++; if (down_m !== 64'h130) $display("FAIL rerun_down got=%h want=130", down_m); else passed++;
        checks++; if (done_m !== 64'h200) $display("FAIL rerun_done got=%h want=200", done_m); else passed++;
        checks++; if (busy_m !== 64'h3FE) $display("FAIL rerun_busy got=%h want=3fe", busy_m); else passed++;
        checks++; if (hv_log[9] !== 4'd2) $display("FAIL rerun_halvings got=%0d want=2", hv_log[9]); else passed++;
    endtask

`ifdef HALFLIFE_ABORT_EN
    task automatic test_abort();
        run(4'd8, 8'd3, 24, 10, 3);
        checks++; if (busy_m !== 64'h7FE) $display("FAIL abort_busy got=%h want=7fe", busy_m); else passed++;
        checks++; if (done_m !== 64'h0) $display("FAIL abort_done got=%h want=0", done_m); else passed++;
        checks++; if (down_m !== 64'h1E0) $display("FAIL abort_down got=%h want=1e0", down_m); else passed++;
        checks++; if (sh_log[11] !== 4'd4) $display("FAIL abort_shadow got=%0d want=4", sh_log[11]); else passed++;
        checks++; if (sh_log[23] !== 4'd4) $display("FAIL abort_shadow_hold got=%0d want=4", sh_log[23]); else passed++;
        checks++; if (hv_log[23] !== 4'd1) $display("FAIL abort_halvings got=%0d want=1", hv_log[23]); else passed++;
    endtask
`endif

    initial begin
        bus.start = 1'b0;
        bus.init_count = '0;
        bus.half_life = '0;
`ifdef HALFLIFE_ABORT_EN
        bus.abort = 1'b0;
`endif
        test_reset();
        test_basic();
        test_zero_init();
        test_hl_zero();
        test_start_ignored();
        test_reset_mid_run();
`ifdef HALFLIFE_ABORT_EN
        test_abort();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/halflife_sequencer.md
# halflife_sequencer

Command-side initiator for the half-life counter. It loads an initial population into the downstream loadable up/down counter, then issues down-count commands at each half-life boundary, removing ceil(count/2) per half-life until the population reaches zero. It keeps a shadow copy of the counter value and reports progress through a start/busy/done handshake. It sits between the control logic and the counter, driving the counter's load/down command inputs.

## Interface
- `N`, 4, population/counter width; matches the counter's width
- `HL_W`, 8, width of the half-life period field, in clock cycles
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin a run; sampled only in IDLE
- `init_count`  in  N  initial population; captured on accepted `start`
- `half_life`  in  HL_W  cycles per half-life; captured on accepted `start`; 0 treated as 1
- `cmd_load`  out  1  load command to the counter
- `load_val`  out  N  value accompanying `cmd_load`; 0 otherwise
- `cmd_down`  out  1  decrement command to the counter, one unit per cycle asserted
- `shadow_count`  out  N  sequencer's model of the counter value
- `halvings`  out  N  completed half-life steps this run; saturates at all-ones
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse at run completion

## Operation
- States:
  - IDLE: all commands low; `start`=1 captures inputs, goes to LOAD.
  - LOAD: `cmd_load`=1 and `load_val`=init for one cycle; `shadow_count`←init and `halvings`←0. If init==0, go to DONE; otherwise go to WAIT.
  - WAIT: lasts exactly `half_life` cycles (minimum 1), then computes quota = shadow − (shadow>>1) and goes to DECAY.
  - DECAY: `cmd_down`=1 for exactly quota consecutive cycles, each cycle decrementing shadow. After the last pulse, `halvings`++. If shadow reaches 0, go to DONE; otherwise go to WAIT.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- `cmd_load` and `cmd_down` are never asserted together. `cmd_down` never drives shadow below 0.
- `start` is ignored while `busy`. Changes to `init_count`/`half_life` during a run have no effect.
- All arithmetic is unsigned, N bits. No wrap-around is possible: quota ≤ shadow.

## Timing
- Reset values: all outputs 0, state IDLE.
- Reset mid-run: next cycle is IDLE with all commands low, no `done`, and shadow/`halvings` cleared.
- All outputs are registered. `start` high at edge k puts LOAD in cycle k+1.
- `shadow_count` updates on the same edge that ends the command cycle, so it equals the counter's value one cycle after each command.
- Total down pulses per run = init. Run length = 2 + init + halvings×`half_life` cycles, counted from LOAD through DONE.
- `done` and `busy` both assert in the DONE cycle. `busy` drops in the following cycle.

## Configuration
- `HALFLIFE_ABORT_EN` defined: adds input `abort` (1 bit).
  - `abort`=1 in any non-IDLE state: the next cycle is IDLE, commands are low, no `done` pulse.
  - `shadow_count` and `halvings` hold their last values until the next start.
  - `abort` has priority over state transitions; `rst` has priority over `abort`.
- `HALFLIFE_ABORT_EN` undefined: the `abort` port does not exist and runs always complete.

## Structure
- Shared package `halflife_pkg`:
  - state enum typedef (IDLE, LOAD, WAIT, DECAY, DONE)
  - default `N`/`HL_W` constants
  - quota function ceil(x/2)
- Sub-module `halflife_period_timer`:
  - loadable down-counter of width `HL_W`, with `load`, `value` and a `expire` pulse
  - used for WAIT; loads max(`half_life`,1)

## Test plan
- init=8, hl=3, `start` at cycle 0:
  - `cmd_load` in cycle 1 with `load_val`=8
  - `cmd_down` bursts of 4/2/1/1 in cycles 5–8, 12–13, 17, 21
  - `done` in cycle 22; `halvings`=4, shadow=0
- init=0, hl=5 → LOAD, then DONE in cycle 2; no `cmd_down`; `halvings`=0.
- init=15, hl=0 → `half_life` treated as 1; bursts of 8/4/2/1; `halvings`=4; total down pulses=15.
- `start` pulsed in cycle 6 of a running job → ignored; captured values unchanged; the single `done` occurs on schedule.
- `rst` asserted in the middle of a DECAY burst → next cycle all outputs 0 and state IDLE; a new `start` (init=3, hl=2) completes with `halvings`=2.
- With `HALFLIFE_ABORT_EN`: `abort` during WAIT of the init=8 run → IDLE next cycle, no `done`, shadow held at 4.
